keypad_scan: RTL

Matrix-keypad scanner for the 4x4 hex keypad: drives one active-low column at a time, samples the four active-low row lines, debounces, and reports one 4-bit key code per press. It is the input-side counterpart of the multiplexed seven-segment driver. Its key codes use the same 0–F digit encoding, so game logic can route a key straight to a display digit.

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_sync2.sv | 22 ++
 rtl/keypad_scan.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Key codes use the same 0-F digit encoding as the seven-segment driver.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    localparam logic [3:0] COL0_N = 4'b1110;
    localparam logic [3:0] COL1_N = 4'b1101;
    localparam logic [3:0] COL2_N = 4'b1011;
    localparam logic [3:0] COL3_N = 4'b0111;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // 4*r + c is simply the row index concatenated above the column index.
    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] drive;
        unique case (c)
            2'd0:    drive = COL0_N;
            2'd1:    drive = COL1_N;
            2'd2:    drive = COL2_N;
            default: drive = COL3_N;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the four active-low row lines.
// Resets to all-released (4'b1111) so no phantom press appears after reset.
module keypad_sync2 (
    input  logic       f_cst,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge f_cst) begin
        if (rst) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, debounced press/release, one code per press.
// Optional auto-repeat while held is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_CYCLES     = 16'd50000,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd10000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
`endif
) (
    input  logic       f_cst,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output state_t     fsm_state
);

    logic [3:0]  row_s;
    state_t      state;
    logic [1:0]  col;
    logic [15:0] slot_cnt;
    logic [19:0] db_cnt;
    logic [1:0]  r_lat;
    logic [1:0]  c_lat;
`ifdef KEYPAD_REPEAT_EN
    logic [23:0] rep_cnt;
    logic        rep_first;
`endif

    keypad_sync2 u_sync (
        .f_cst (f_cst),
        .rst   (rst),
        .d     (row_n),
        .q     (row_s)
    );

    // Lowest-numbered active row wins when several keys share a column.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        return r;
    endfunction

    assign fsm_state = state;

    always_ff @(posedge f_cst) begin
        if (rst) begin
            state     <= SCAN;
            col       <= 2'd0;
            col_n     <= COL0_N;
            slot_cnt  <= 16'd0;
            db_cnt    <= 20'd0;
            r_lat     <= 2'd0;
            c_lat     <= 2'd0;
            key_code  <= KEY_0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= 24'd0;
            rep_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (slot_cnt == SCAN_CYCLES - 16'd1) begin
                        slot_cnt <= 16'd0;
                        if (row_s != 4'b1111) begin
                            r_lat  <= low_row(row_s);
                            c_lat  <= col;
                            db_cnt <= 20'd0;
                            state  <= DEBOUNCE;
                        end else begin
                            col   <= col + 2'd1;
                            col_n <= col_drive(col + 2'd1);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 16'd1;
                    end
                end

                DEBOUNCE: begin
                    if (row_s[r_lat]) begin
                        // Bounce: abandon this key and resume after its column.
                        state    <= SCAN;
                        col      <= c_lat + 2'd1;
                        col_n    <= col_drive(c_lat + 2'd1);
                        slot_cnt <= 16'd0;
                        db_cnt   <= 20'd0;
                    end else if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                        state     <= HOLD;
                        key_valid <= 1'b1;
                        key_code  <= code_of(r_lat, c_lat);
                        key_down  <= 1'b1;
                        db_cnt    <= 20'd0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= 24'd0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        db_cnt <= db_cnt + 20'd1;
                    end
                end

                HOLD: begin
                    if (row_s[r_lat]) begin
                        if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                            state    <= SCAN;
                            key_down <= 1'b0;
                            col      <= c_lat + 2'd1;
                            col_n    <= col_drive(c_lat + 2'd1);
                            slot_cnt <= 16'd0;
                            db_cnt   <= 20'd0;
                        end else begin
                            db_cnt <= db_cnt + 20'd1;
                        end
                    end else begin
                        db_cnt <= 20'd0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                    if (row_s[r_lat]) begin
                        rep_cnt <= 24'd0;
                    end else if (rep_cnt == (rep_first ? REPEAT_DELAY - 24'd1
                                                       : REPEAT_PERIOD - 24'd1)) begin
                        key_valid <= 1'b1;
                        rep_cnt   <= 24'd0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 24'd1;
                    end
`endif
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule
